instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 4, meaning the instruction queue depth (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_req_addr  output  64  byte address of the requested word.
REQ-008 SHALL have port imem_resp_valid  input  1  response word valid; responses return in request order, latency 1 or more cycles.
REQ-009 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  taken-branch redirect from the pc-select mux.
REQ-011 SHALL have port redirect_pc  input  64  redirect target address.
REQ-012 SHALL have port if_valid  output  1  instruction available to decode.
REQ-013 SHALL have port if_ready  input  1  decode consumes the instruction.
REQ-014 SHALL have port if_instr  output  32  instruction at queue head.
REQ-015 SHALL have port if_pc  output  64  PC of if_instr.

Function
REQ-016 SHALL implement FSM states BOOT and RUN: reset enters BOOT; BOOT goes to RUN after one clk edge; RUN holds until reset.
REQ-017 SHALL deassert imem_req_valid in BOOT.
REQ-018 SHALL, in RUN, assert imem_req_valid when (queue occupancy + live outstanding + killed outstanding) < QDEPTH and redirect_valid is 0.
REQ-019 SHALL drive imem_req_addr from fetch_pc and advance fetch_pc by 4 (64-bit wrap, 0xFFFF_FFFF_FFFF_FFFC to 0) on each req_valid && req_ready.
REQ-020 SHALL hold imem_req_addr stable while req_valid is high and req_ready is low.
REQ-021 SHALL keep a tag FIFO of issued PCs (depth QDEPTH) so each accepted response is written to the queue with its PC.
REQ-022 SHALL write a non-killed response into the queue on the edge where it arrives, with no combinational bypass; if_valid rises at the earliest one cycle after imem_resp_valid.
REQ-023 SHALL drive if_valid = queue not empty, and drive if_instr and if_pc from the queue head.
REQ-024 SHALL pop the head on if_valid && if_ready.
REQ-025 SHALL allow push and pop in the same cycle when full, leaving occupancy unchanged.
REQ-026 SHALL, on redirect_valid, set fetch_pc = {redirect_pc[63:2], 2'b00}, flush the queue and the tag FIFO, and move all live outstanding requests to a kill counter.
REQ-027 SHALL count a response arriving in the redirect cycle as killed.
REQ-028 SHALL discard responses while the kill counter is non-zero and decrement the counter by 1 per discarded response.
REQ-029 SHALL let a decode handshake in the redirect cycle complete normally (head transferred), then flush.
REQ-030 SHALL give redirect priority over issue and push in the same cycle; pop still completes per REQ-029.
REQ-031 SHALL accept a redirect during a non-zero kill count, accumulating the outstanding requests into the kill counter.
REQ-032 SHALL update counters by net effect when request acceptance and response occur in the same cycle.
REQ-033 SHALL guarantee the queue never overflows, because a slot is reserved at issue time.

Reset
REQ-034 SHALL, on reset low, immediately set: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, queue/tag/kill counters=0, fetch_pc=RESET_PC, state BOOT.
REQ-035 SHALL, on reset asserted mid-transaction, drop all in-flight state; responses arriving while reset is low are ignored.
REQ-036 SHALL issue the first request at RESET_PC in the second rising edge after reset deasserts.

Verification
REQ-037 Boot: RESET_PC=0x1000, memory latency 1, if_ready=1 -> addresses 0x1000, 0x1004, 0x1008 in order; if_pc matches each instruction.
REQ-038 Backpressure: if_ready=0, QDEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; the queue holds 0x0..0xC; releasing if_ready resumes at 0x10.
REQ-039 Redirect with 3 outstanding (latency 5): redirect_pc=0x2002 -> next request addr 0x2000; 3 stale responses discarded; first if_pc=0x2000.
REQ-040 Simultaneous: redirect, pop and response in one cycle -> head delivered once, response killed, queue empty next cycle.
REQ-041 Wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC -> next request addr 0x0.
REQ-042 Reset mid-burst: reset low with 2 outstanding -> outputs zero immediately; after release, fetch restarts at RESET_PC and no stale word is delivered.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tags them with their PC, and queues
// returned instructions for decode. A redirect flushes the queue and kills in-flight responses.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc
);

    localparam int unsigned PW = $clog2(QDEPTH);
    // Wide enough for the sum of all three counters.
    localparam int unsigned CW = PW + 2;

    typedef enum logic {StBoot, StRun} state_e;

    state_e         r_state;
    state_e         w_state_next;

    logic [63:0]    r_fetch_pc;

    logic [31:0]    r_q_instr [QDEPTH];
    logic [63:0]    r_q_pc    [QDEPTH];
    logic [PW-1:0]  r_q_wptr;
    logic [PW-1:0]  r_q_rptr;
    logic [CW-1:0]  r_q_cnt;

    logic [63:0]    r_t_pc    [QDEPTH];
    logic [PW-1:0]  r_t_wptr;
    logic [PW-1:0]  r_t_rptr;
    logic [CW-1:0]  r_t_cnt;

    logic [CW-1:0]  r_kill_cnt;

    logic [CW-1:0]  w_reserved;
    logic           w_accept;
    logic           w_resp_kill;
    logic           w_resp_live;
    logic           w_push;
    logic           w_pop;
    logic           w_unused_pc_lsb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StBoot;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StBoot:  w_state_next = StRun;
            StRun:   w_state_next = StRun;
            default: w_state_next = StBoot;
        endcase
    end

    // Every slot is claimed at issue time, so the queue can never overflow.
    assign w_reserved     = r_q_cnt + r_t_cnt + r_kill_cnt;
    assign imem_req_valid = (r_state == StRun) && (w_reserved < CW'(QDEPTH)) && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;

    assign w_accept    = imem_req_valid && imem_req_ready;
    assign w_resp_kill = imem_resp_valid && (r_kill_cnt != '0);
    assign w_resp_live = imem_resp_valid && (r_kill_cnt == '0) && (r_t_cnt != '0);
    assign w_push      = w_resp_live && !redirect_valid;
    assign w_pop       = if_valid && if_ready;

    assign if_valid = (r_q_cnt != '0);
    assign if_instr = r_q_instr[r_q_rptr];
    assign if_pc    = r_q_pc[r_q_rptr];

    assign w_unused_pc_lsb = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
            r_q_cnt    <= '0;
            r_t_wptr   <= '0;
            r_t_rptr   <= '0;
            r_t_cnt    <= '0;
            r_kill_cnt <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_t_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // A response in this cycle is discarded whether it was live or already killed.
            r_fetch_pc <= {redirect_pc[63:2], 2'b00};
            r_q_wptr   <= '0;
            r_q_rptr   <= '0;
            r_q_cnt    <= '0;
            r_t_wptr   <= '0;
            r_t_rptr   <= '0;
            r_t_cnt    <= '0;
            r_kill_cnt <= r_kill_cnt + r_t_cnt - CW'(w_resp_kill || w_resp_live);
        end else begin
            if (w_accept) begin
                r_fetch_pc       <= r_fetch_pc + 64'd4;
                r_t_pc[r_t_wptr] <= r_fetch_pc;
                r_t_wptr         <= r_t_wptr + PW'(1);
            end
            if (w_resp_live) begin
                r_t_rptr <= r_t_rptr + PW'(1);
            end
            r_t_cnt <= r_t_cnt + CW'(w_accept) - CW'(w_resp_live);

            if (w_push) begin
                r_q_instr[r_q_wptr] <= imem_resp_data;
                r_q_pc[r_q_wptr]    <= r_t_pc[r_t_rptr];
                r_q_wptr            <= r_q_wptr + PW'(1);
            end
            if (w_pop) begin
                r_q_rptr <= r_q_rptr + PW'(1);
            end
            r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);

            if (w_resp_kill) begin
                r_kill_cnt <= r_kill_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit: an in-order memory model plus an epoch-based
// reference of which fetched words decode must see, and at which PCs.
module tb_instruction_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          QD     = 4;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    instruction_fetch_unit #(
        .RESET_PC (RST_PC),
        .QDEPTH   (QD)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       mem_q[$];
    ent_t        mq[$];
    logic [63:0] m_fetch_pc;
    int          m_epoch;
    int          cyc;
    int          since_rst;
    int          n_cmp;
    int          n_bad;
    bit          force_redir;
    logic [63:0] force_pc;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        mq.delete();
        m_fetch_pc = RST_PC;
        m_epoch++;
        since_rst = 0;
    endtask

    task automatic check_reset_outputs();
        check_val("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check_val("rst_req_addr", imem_req_addr, RST_PC);
        check_val("rst_if_valid", 64'(if_valid), 64'd0);
        check_val("rst_if_instr", 64'(if_instr), 64'd0);
        check_val("rst_if_pc", if_pc, 64'd0);
    endtask

    task automatic run_cycles(input int n, input int p_redir, input int p_ifr, input int p_rr,
                              input int lat_max, input int p_resp);
        bit          exp_rv;
        bit          exp_ifv;
        bit          do_redir;
        logic [63:0] rpc;
        mreq_t       r;
        ent_t        e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            do_redir = force_redir || (int'($urandom_range(99)) < p_redir);
            rpc = force_redir ? force_pc : {32'($urandom_range(3)), 32'($urandom)};
            force_redir = 1'b0;
            redirect_valid = do_redir;
            redirect_pc    = rpc;
            if_ready       = int'($urandom_range(99)) < p_ifr;
            imem_req_ready = int'($urandom_range(99)) < p_rr;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc && int'($urandom_range(99)) < p_resp) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(mem_q[0].addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom;
            end
            #1;
            exp_ifv = mq.size() != 0;
            check_val("if_valid", 64'(if_valid), 64'(exp_ifv));
            if (exp_ifv) begin
                check_val("if_pc", if_pc, mq[0].pc);
                check_val("if_instr", 64'(if_instr), 64'(mq[0].instr));
            end
            exp_rv = since_rst >= 1 && (mq.size() + mem_q.size()) < QD && !do_redir;
            check_val("req_valid", 64'(imem_req_valid), 64'(exp_rv));
            if (exp_rv) check_val("req_addr", imem_req_addr, m_fetch_pc);

            if (exp_ifv && if_ready) void'(mq.pop_front());
            if (imem_resp_valid) begin
                r = mem_q.pop_front();
                if (r.epoch == m_epoch && !do_redir) begin
                    e.pc    = r.addr;
                    e.instr = word_of(r.addr);
                    mq.push_back(e);
                end
            end
            if (exp_rv && imem_req_ready) begin
                r.addr  = m_fetch_pc;
                r.epoch = m_epoch;
                r.due   = cyc + int'($urandom_range(lat_max, 1));
                mem_q.push_back(r);
                m_fetch_pc = m_fetch_pc + 64'd4;
            end
            if (do_redir) begin
                m_epoch++;
                mq.delete();
                m_fetch_pc = {rpc[63:2], 2'b00};
            end
            @(posedge clk);
            cyc++;
            since_rst++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        m_epoch = 0;
        force_redir = 1'b0;
        force_pc = '0;
        reset = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        if_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(posedge clk);
        #2 reset = 1'b1;

        // Boot with single-cycle memory and a free-running decoder.
        run_cycles(30, 0, 100, 100, 1, 100);
        // Decoder stalled: fetch must stop once QD slots are claimed, then resume.
        run_cycles(20, 0, 0, 100, 1, 100);
        run_cycles(20, 0, 100, 100, 1, 100);
        // Long latency with redirects and random handshakes.
        run_cycles(1500, 4, 70, 70, 5, 70);
        run_cycles(500, 10, 90, 90, 2, 90);

        // Redirect to the last word of the address space; fetch wraps to zero.
        force_redir = 1'b1;
        force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        run_cycles(40, 0, 80, 90, 3, 90);

        // Reset mid-burst with requests still outstanding and a response during reset.
        run_cycles(6, 0, 0, 100, 5, 100);
        @(negedge clk);
        reset = 1'b0;
        redirect_valid = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data = 32'hDEAD_BEEF;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        model_reset();
        imem_resp_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        run_cycles(400, 3, 70, 70, 4, 70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
